// File: rtl/sonic_trigger_seq_if.sv
// ============================================================================
// Module   : sonic_trigger_seq_if
// Brief    : Control/echo signal bundle between the ultrasonic trigger
//            sequencer and its environment (controller side = master).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sonic_trigger_seq_if;
    logic enable;
    logic single_shot;
    logic echo_raw;
    logic trigger;
    logic echo_sync;
    logic busy;
    logic meas_done;
    logic timeout;
    logic fault;

    modport master (
        output enable, single_shot, echo_raw,
        input  trigger, echo_sync, busy, meas_done, timeout, fault
    );

    modport slave (
        input  enable, single_shot, echo_raw,
        output trigger, echo_sync, busy, meas_done, timeout, fault
    );
endinterface

`default_nettype wire

// File: rtl/sonic_trigger_seq.sv
// ============================================================================
// Module   : sonic_trigger_seq
// Brief    : Ultrasonic ranging sequencer: periodic/single-shot trigger,
//            echo synchroniser and rise/width supervision.
//            Optional echo deglitch filter: SONIC_GLITCH_FILTER_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sonic_trigger_seq #(
    parameter int CNT_W         = 22,
    parameter int TRIG_CYCLES   = 500,
    parameter int PERIOD_CYCLES = 3000000,
    parameter int RISE_TIMEOUT  = 1500000,
    parameter int MAX_ECHO      = 1250000,
    parameter int GLITCH_CYCLES = 8
) (
    input  wire logic         CLOCK_50,
    input  wire logic         reset_n,
    sonic_trigger_seq_if.slave bus
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_TRIG      = 3'd1;
    localparam logic [2:0] S_WAIT_RISE = 3'd2;
    localparam logic [2:0] S_ECHO_HI   = 3'd3;
    localparam logic [2:0] S_HOLDOFF   = 3'd4;

    localparam logic [CNT_W-1:0] c_ONE         = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_TRIG_LAST   = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_PERIOD_LAST = CNT_W'(PERIOD_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_RISE_LAST   = CNT_W'(RISE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_ECHO_LAST   = CNT_W'(MAX_ECHO - 1);

    if ((TRIG_CYCLES < 1) || (GLITCH_CYCLES < 1) ||
        (PERIOD_CYCLES <= TRIG_CYCLES + RISE_TIMEOUT + MAX_ECHO) ||
        (longint'(PERIOD_CYCLES) >= (longint'(1) << CNT_W))) begin : g_param_check
        $error("sonic_trigger_seq: illegal parameter combination");
    end

    logic             r_sync1;
    logic             r_sync2;
    logic             w_echo;
    logic             r_echo_d;
    logic             w_rise;
    logic             w_fall;
    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_period_cnt;
    logic [CNT_W-1:0] r_phase_cnt;
    logic             r_trigger;
    logic             r_meas_done;
    logic             r_timeout;
    logic             r_fault;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= bus.echo_raw;
            r_sync2 <= r_sync1;
        end
    end

`ifdef SONIC_GLITCH_FILTER_EN
    localparam int              c_GW          = (GLITCH_CYCLES > 1) ? $clog2(GLITCH_CYCLES) : 1;
    localparam logic [c_GW-1:0] c_GLITCH_LAST = c_GW'(GLITCH_CYCLES - 1);
    localparam logic [c_GW-1:0] c_G_ONE       = c_GW'(1);

    logic [c_GW-1:0] r_glitch_cnt;
    logic            r_filt;

    // Output follows the synchroniser only after an unbroken run of identical samples.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_glitch_cnt <= '0;
            r_filt       <= 1'b0;
        end else if (r_sync2 == r_filt) begin
            r_glitch_cnt <= '0;
        end else if (r_glitch_cnt == c_GLITCH_LAST) begin
            r_filt       <= r_sync2;
            r_glitch_cnt <= '0;
        end else begin
            r_glitch_cnt <= r_glitch_cnt + c_G_ONE;
        end
    end

    assign w_echo = r_filt;
`else
    assign w_echo = r_sync2;
`endif

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_echo_d <= 1'b0;
        end else begin
            r_echo_d <= w_echo;
        end
    end

    assign w_rise = w_echo & ~r_echo_d;
    assign w_fall = ~w_echo & r_echo_d;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_period_cnt <= '0;
            r_phase_cnt  <= '0;
            r_trigger    <= 1'b0;
            r_meas_done  <= 1'b0;
            r_timeout    <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_meas_done <= 1'b0;
            r_timeout   <= 1'b0;
            r_fault     <= 1'b0;

            // Period counter runs from the trigger rise and parks at its last value.
            if (r_period_cnt != c_PERIOD_LAST) begin
                r_period_cnt <= r_period_cnt + c_ONE;
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.enable || bus.single_shot) begin
                        r_state      <= S_TRIG;
                        r_trigger    <= 1'b1;
                        r_period_cnt <= '0;
                        r_phase_cnt  <= '0;
                    end
                end
                S_TRIG: begin
                    if (r_phase_cnt == c_TRIG_LAST) begin
                        r_trigger   <= 1'b0;
                        r_state     <= S_WAIT_RISE;
                        r_phase_cnt <= '0;
                    end else begin
                        r_phase_cnt <= r_phase_cnt + c_ONE;
                    end
                end
                S_WAIT_RISE: begin
                    if (w_rise) begin
                        r_state     <= S_ECHO_HI;
                        r_phase_cnt <= '0;
                    end else if (r_phase_cnt == c_RISE_LAST) begin
                        r_timeout <= 1'b1;
                        r_state   <= S_HOLDOFF;
                    end else begin
                        r_phase_cnt <= r_phase_cnt + c_ONE;
                    end
                end
                S_ECHO_HI: begin
                    if (w_fall) begin
                        r_meas_done <= 1'b1;
                        r_state     <= S_HOLDOFF;
                    end else if (r_phase_cnt == c_ECHO_LAST) begin
                        r_fault <= 1'b1;
                        r_state <= S_HOLDOFF;
                    end else begin
                        r_phase_cnt <= r_phase_cnt + c_ONE;
                    end
                end
                S_HOLDOFF: begin
                    // A stuck-high echo keeps us here so the sensor is never re-fired into it.
                    if ((r_period_cnt == c_PERIOD_LAST) && !w_echo) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_trigger <= 1'b0;
                end
            endcase
        end
    end

    assign bus.trigger   = r_trigger;
    assign bus.echo_sync = w_echo;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.meas_done = r_meas_done;
    assign bus.timeout   = r_timeout;
    assign bus.fault     = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_sonic_trigger_seq.sv
// ============================================================================
// Module   : tb_sonic_trigger_seq
// Brief    : Self-checking bench for sonic_trigger_seq with small parameters
//            and an event-timing reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sonic_trigger_seq;

    localparam int c_TRIG     = 5;
    localparam int c_PERIOD   = 200;
    localparam int c_RISE_TO  = 50;
    localparam int c_MAX_ECHO = 60;
    localparam int c_GLITCH   = 4;
`ifdef SONIC_GLITCH_FILTER_EN
    localparam int c_LAT = 2 + c_GLITCH;
`else
    localparam int c_LAT = 2;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    sonic_trigger_seq_if u_if ();

    sonic_trigger_seq #(
        .CNT_W         (22),
        .TRIG_CYCLES   (c_TRIG),
        .PERIOD_CYCLES (c_PERIOD),
        .RISE_TIMEOUT  (c_RISE_TO),
        .MAX_ECHO      (c_MAX_ECHO),
        .GLITCH_CYCLES (c_GLITCH)
    ) u_dut (
        .CLOCK_50 (clk),
        .reset_n  (rst_n),
        .bus      (u_if)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event log: cycle numbers at which each output was first seen high.
    int   rise_q[$], fall_q[$], meas_q[$], to_q[$], fault_q[$], sync_q[$];
    logic prev_trig = 1'b0;
    logic prev_sync = 1'b0;
    int   excl_viol = 0;

    always @(negedge clk) begin
        if (u_if.trigger && !prev_trig) rise_q.push_back(cyc);
        if (!u_if.trigger && prev_trig) fall_q.push_back(cyc);
        if (u_if.echo_sync && !prev_sync) sync_q.push_back(cyc);
        if (u_if.meas_done) meas_q.push_back(cyc);
        if (u_if.timeout) to_q.push_back(cyc);
        if (u_if.fault) fault_q.push_back(cyc);
        if ((int'(u_if.meas_done) + int'(u_if.timeout) + int'(u_if.fault)) > 1)
            excl_viol <= excl_viol + 1;
        prev_trig <= u_if.trigger;
        prev_sync <= u_if.echo_sync;
    end

    int n_pass   = 0;
    int n_checks = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_ss();
        u_if.single_shot = 1'b1;
        tick();
        u_if.single_shot = 1'b0;
    endtask

    task automatic clear_logs();
        rise_q.delete(); fall_q.delete(); meas_q.delete();
        to_q.delete();   fault_q.delete(); sync_q.delete();
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Outcome of one ranging cycle from the timing rules: R = trigger rise,
    // F = trigger fall, c = cycle echo_raw was raised, W = echo width (0 = none).
    // kind: 0 meas_done, 1 timeout, 2 fault.
    function automatic void model(input int R, input int F, input int c, input int W,
                                  output int kind, output int t_ev, output int t_idle);
        int seen_rise;
        seen_rise = c + c_LAT + 1;
        if (W == 0) begin
            kind   = 1;
            t_ev   = F + c_RISE_TO;
            t_idle = R + c_PERIOD;
        end else begin
            if (seen_rise > F + c_RISE_TO) begin
                kind = 1;
                t_ev = F + c_RISE_TO;
            end else if (W <= c_MAX_ECHO) begin
                kind = 0;
                t_ev = c + W + c_LAT + 1;
            end else begin
                kind = 2;
                t_ev = seen_rise + c_MAX_ECHO;
            end
            t_idle = imax(R + c_PERIOD, c + W + c_LAT + 1);
        end
    endfunction

    task automatic wait_log(ref int q[$], input string tag, output int t);
        int k;
        k = 0;
        while (q.size() == 0 && k < 1000) begin
            tick();
            k++;
        end
        check({tag, "/seen"}, int'(q.size() > 0), 1);
        t = (q.size() > 0) ? q.pop_front() : -1;
    endtask

    task automatic range_cycle(input string tag, input int D, input int W, input bit drop_en,
                               input bit ss_busy, input bit glitch, output int R, output int e);
        int F, c, kind, t_ev, t_idle, k, n_ev, got_kind, got_t;
        c = 0;
        wait_log(rise_q, {tag, "/rise"}, R);
        if (drop_en) u_if.enable = 1'b0;
        if (ss_busy) pulse_ss();
        wait_log(fall_q, {tag, "/fall"}, F);
        check({tag, "/trig_width"}, F - R, c_TRIG);
        if (glitch) begin
            u_if.echo_raw = 1'b1;
            repeat (3) tick();
            u_if.echo_raw = 1'b0;
            repeat (10) tick();
        end
        if (W > 0) begin
            repeat (D) tick();
            u_if.echo_raw = 1'b1;
            c = cyc;
            repeat (W) tick();
            u_if.echo_raw = 1'b0;
        end
        model(R, F, c, W, kind, t_ev, t_idle);
        k = 0;
        while (u_if.busy && k < 2000) begin
            tick();
            k++;
        end
        e = cyc;
        check({tag, "/idle_cycle"}, e, t_idle);
        n_ev = meas_q.size() + to_q.size() + fault_q.size();
        check({tag, "/n_events"}, n_ev, 1);
        got_kind = (meas_q.size() > 0) ? 0 : (to_q.size() > 0) ? 1 : (fault_q.size() > 0) ? 2 : -1;
        check({tag, "/kind"}, got_kind, kind);
        got_t = (got_kind == 0) ? meas_q[0] : (got_kind == 1) ? to_q[0] :
                (got_kind == 2) ? fault_q[0] : -1;
        check({tag, "/event_cycle"}, got_t, t_ev);
        check({tag, "/sync_edges"}, sync_q.size(), int'(W > 0));
        if (W > 0 && sync_q.size() > 0) check({tag, "/sync_latency"}, sync_q[0] - c, c_LAT);
        meas_q.delete(); to_q.delete(); fault_q.delete(); sync_q.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int R, e, prev_R, prev_e, n, D, W;
        int bd_D[6];
        int bd_W[6];

        u_if.enable      = 1'b0;
        u_if.single_shot = 1'b0;
        u_if.echo_raw    = 1'b0;

        repeat (3) tick();
        check("reset_outputs", int'({u_if.trigger, u_if.echo_sync, u_if.busy,
                                     u_if.meas_done, u_if.timeout, u_if.fault}), 0);
        rst_n = 1'b1;
        repeat (5) tick();
        check("release_outputs", int'({u_if.trigger, u_if.echo_sync, u_if.busy,
                                       u_if.meas_done, u_if.timeout, u_if.fault}), 0);
        check("release_events", rise_q.size() + meas_q.size() + to_q.size() + fault_q.size(), 0);

        // Continuous ranging with randomised normal echoes.
        n = cyc;
        u_if.enable = 1'b1;
        range_cycle("cont0", 20, 30, 1'b0, 1'b0, 1'b0, R, e);
        check("first_rise_latency", R - n, 1);
        prev_R = R;
        prev_e = e;
        for (int i = 1; i < 4; i++) begin
            D = $urandom_range(0, c_RISE_TO - c_LAT - 2);
            W = $urandom_range(10, c_MAX_ECHO - 1);
            range_cycle("cont_rand", D, W, 1'b0, 1'b0, 1'b0, R, e);
            check("cont_spacing", R - prev_R, c_PERIOD + 1);
            prev_R = R;
            prev_e = e;
        end

        // Rise-window and width boundaries, no echo, then stuck echo with enable dropped.
        bd_D = '{c_RISE_TO - c_LAT - 1, c_RISE_TO - c_LAT, 10, 10, 0, 3};
        bd_W = '{20, 20, c_MAX_ECHO, c_MAX_ECHO + 1, 0, 250};
        for (int i = 0; i < 6; i++) begin
            range_cycle("boundary", bd_D[i], bd_W[i], (i == 5), 1'b0, 1'b0, R, e);
            check("boundary_rise_after_idle", R - prev_e, 1);
            prev_e = e;
        end
        repeat (300) tick();
        check("no_trigger_after_enable_drop", rise_q.size(), 0);

        // Single shot, echo never rises, second single_shot while busy.
        n = cyc;
        pulse_ss();
        range_cycle("ss_timeout", 0, 0, 1'b0, 1'b1, 1'b0, R, e);
        check("ss_rise_latency", R - n, 1);
        repeat (300) tick();
        check("ss_one_trigger", rise_q.size(), 0);

        // Asynchronous reset in the middle of an echo.
        pulse_ss();
        n = 0;
        while (fall_q.size() == 0 && n < 1000) begin
            tick();
            n++;
        end
        repeat (5) tick();
        u_if.echo_raw = 1'b1;
        repeat (c_LAT + 10) tick();
        check("pre_reset_busy", int'(u_if.busy), 1);
        #2 rst_n = 1'b0;
        #2;
        check("async_reset_outputs", int'({u_if.trigger, u_if.echo_sync, u_if.busy,
                                           u_if.meas_done, u_if.timeout, u_if.fault}), 0);
        clear_logs();
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        u_if.echo_raw = 1'b0;
        repeat (100) tick();
        check("post_reset_events", meas_q.size() + to_q.size() + fault_q.size() + rise_q.size(), 0);
        check("post_reset_busy", int'(u_if.busy), 0);
        clear_logs();

`ifdef SONIC_GLITCH_FILTER_EN
        pulse_ss();
        range_cycle("glitch", 0, 30, 1'b0, 1'b0, 1'b1, R, e);
`endif

        check("outcome_exclusive", excl_viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
